// File: rtl/gelato_banked_register_file_if.sv
// Bundles the read-request/response and writeback handshakes of the banked register file.
// master = operand collector / writeback side that issues requests, slave = the register file.
// All per-channel fields are packed side by side, with channel 0 in the least significant slot.
interface gelato_banked_register_file_if #(
  parameter int NUM_RD = 3,
  parameter int NUM_WB = 2,
  parameter int WARP_W = 3,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic [NUM_RD-1:0]        rd_req_valid;
  logic [NUM_RD-1:0]        rd_req_ready;
  logic [NUM_RD*WARP_W-1:0] rd_req_warp;
  logic [NUM_RD*REG_W-1:0]  rd_req_reg;
  logic [NUM_RD-1:0]        rd_resp_valid;
  logic [NUM_RD*DATA_W-1:0] rd_resp_data;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB-1:0]        wb_ready;
  logic [NUM_WB*WARP_W-1:0] wb_warp;
  logic [NUM_WB*REG_W-1:0]  wb_reg;
  logic [NUM_WB*DATA_W-1:0] wb_data;

  modport master (
    output rd_req_valid, rd_req_warp, rd_req_reg, wb_valid, wb_warp, wb_reg, wb_data,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wb_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_warp, rd_req_reg, wb_valid, wb_warp, wb_reg, wb_data,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wb_ready
  );
endinterface

// File: rtl/gelato_banked_register_file.sv
// Purpose: warp-swizzled multi-bank 1R1W register file, round-robin reads, fixed-priority writes.
// Latency: read data one cycle after acceptance; writes commit at the accepting edge.
// Backpressure: ready is combinational from arbitration and rdy; losers hold and retry.
// Optional macro GELATO_RF_WB_BYPASS_EN: same-cycle write to a register being read forwards the new data.
module gelato_banked_register_file #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_RD    = 3,
  parameter int NUM_WB    = 2,
  parameter int NUM_WARPS = 8,
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  gelato_banked_register_file_if.slave rf
);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int REG_W  = $clog2(NUM_REGS);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int RPW    = NUM_REGS / NUM_BANKS;
  localparam int ROWS   = NUM_WARPS * RPW;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CH_W   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int WB_W   = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  // Adding the warp id to the register id rotates each warp's registers across banks.
  function automatic logic [BANK_W-1:0] bank_of(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    return BANK_W'(32'(w) + 32'(r));
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    return ROW_W'(32'(w) * RPW + 32'(r) / NUM_BANKS);
  endfunction

  logic [BANK_W-1:0] rd_bank [NUM_RD];
  logic [ROW_W-1:0]  rd_row  [NUM_RD];
  logic [BANK_W-1:0] wb_bank [NUM_WB];
  logic [ROW_W-1:0]  wb_row  [NUM_WB];

  logic [CH_W-1:0]   rr_q       [NUM_BANKS];
  logic [NUM_BANKS-1:0] rd_hit;
  logic [CH_W-1:0]   rd_win     [NUM_BANKS];
  logic [ROW_W-1:0]  rd_win_row [NUM_BANKS];
  logic [NUM_RD-1:0] rd_gnt;

  logic [NUM_BANKS-1:0] wr_hit;
  logic [WB_W-1:0]   wr_sel [NUM_BANKS];
  logic [ROW_W-1:0]  wr_row [NUM_BANKS];
  logic [DATA_W-1:0] wr_dat [NUM_BANKS];
  logic [NUM_WB-1:0] wb_gnt;

  logic [DATA_W-1:0] mem      [NUM_BANKS][ROWS];
  logic [DATA_W-1:0] bank_q   [NUM_BANKS];
  logic [DATA_W-1:0] bank_out [NUM_BANKS];
  logic [NUM_RD-1:0] resp_vld_q;
  logic [BANK_W-1:0] resp_bank_q [NUM_RD];

  // Decode every channel's warp/reg into its bank and row.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_bank[i] = bank_of(rf.rd_req_warp[i*WARP_W +: WARP_W], rf.rd_req_reg[i*REG_W +: REG_W]);
      rd_row[i]  = row_of(rf.rd_req_warp[i*WARP_W +: WARP_W], rf.rd_req_reg[i*REG_W +: REG_W]);
    end
    for (int j = 0; j < NUM_WB; j++) begin
      wb_bank[j] = bank_of(rf.wb_warp[j*WARP_W +: WARP_W], rf.wb_reg[j*REG_W +: REG_W]);
      wb_row[j]  = row_of(rf.wb_warp[j*WARP_W +: WARP_W], rf.wb_reg[j*REG_W +: REG_W]);
    end
  end

  // Per-bank read arbitration: scan channels starting at rr_q, wrapping, first contender wins.
  always_comb begin : rd_arb
    int idx;
    rd_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_hit[b]     = 1'b0;
      rd_win[b]     = '0;
      rd_win_row[b] = '0;
      for (int k = 0; k < NUM_RD; k++) begin
        idx = int'(rr_q[b]) + k;
        if (idx >= NUM_RD) idx = idx - NUM_RD;
        if (!rd_hit[b] && rf.rd_req_valid[idx] && rd_bank[idx] == BANK_W'(b)) begin
          rd_hit[b]     = 1'b1;
          rd_win[b]     = CH_W'(idx);
          rd_win_row[b] = rd_row[idx];
        end
      end
      if (rd_hit[b] && rdy) rd_gnt[rd_win[b]] = 1'b1;
    end
  end

  // Per-bank write arbitration: lowest-index valid writeback channel wins.
  always_comb begin
    wb_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_hit[b] = 1'b0;
      wr_sel[b] = '0;
      wr_row[b] = '0;
      wr_dat[b] = '0;
      for (int j = 0; j < NUM_WB; j++) begin
        if (!wr_hit[b] && rf.wb_valid[j] && wb_bank[j] == BANK_W'(b)) begin
          wr_hit[b] = 1'b1;
          wr_sel[b] = WB_W'(j);
          wr_row[b] = wb_row[j];
          wr_dat[b] = rf.wb_data[j*DATA_W +: DATA_W];
        end
      end
      if (wr_hit[b] && rdy) wb_gnt[wr_sel[b]] = 1'b1;
    end
  end

  assign rf.rd_req_ready  = rd_gnt;
  assign rf.wb_ready      = wb_gnt;
  assign rf.rd_resp_valid = resp_vld_q;

  // Bank arrays: the read samples the pre-write contents, so a same-row write is seen next time.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rdy && wr_hit[b]) mem[b][wr_row[b]] <= wr_dat[b];
      if (rdy && rd_hit[b]) bank_q[b] <= mem[b][rd_win_row[b]];
    end
  end

  // Response valid, remembered source bank per channel, and round-robin pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
    end else begin
      resp_vld_q <= rd_gnt;
      for (int i = 0; i < NUM_RD; i++)
        if (rd_gnt[i]) resp_bank_q[i] <= rd_bank[i];
      for (int b = 0; b < NUM_BANKS; b++)
        if (rd_hit[b] && rdy)
          rr_q[b] <= (rd_win[b] == CH_W'(NUM_RD - 1)) ? '0 : rd_win[b] + 1'b1;
    end
  end

`ifdef GELATO_RF_WB_BYPASS_EN
  logic [NUM_BANKS-1:0] byp_hit_q;
  logic [DATA_W-1:0]    byp_dat_q [NUM_BANKS];

  // Remember whether this bank's read collided with its write, and the data being written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rdy && rd_hit[b]) begin
        byp_hit_q[b] <= wr_hit[b] && (wr_row[b] == rd_win_row[b]);
        byp_dat_q[b] <= wr_dat[b];
      end
    end
  end

  // Substitute the freshly written value on a collision.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      bank_out[b] = byp_hit_q[b] ? byp_dat_q[b] : bank_q[b];
  end
`else
  // Bank output is the raw array read.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      bank_out[b] = bank_q[b];
  end
`endif

  // Steer each channel's response from the bank it was granted on.
  always_comb begin
    rf.rd_resp_data = '0;
    for (int i = 0; i < NUM_RD; i++)
      rf.rd_resp_data[i*DATA_W +: DATA_W] = bank_out[resp_bank_q[i]];
  end
endmodule

// File: doc/gelato_banked_register_file.md
Name: gelato_banked_register_file

Overview:
- Parametrised, multi-bank warp register file for the Gelato GPU.
- Serves N operand-collector read channels and M writeback channels, with per-bank round-robin read arbitration and fixed-priority write arbitration.
- Warp-swizzled bank mapping spreads same-numbered registers of different warps across banks.
- Sits between the operand collector and the execution-unit writeback paths; replaces the fixed-width bank array plus separate arbiter.

Parameters:
- NUM_BANKS, 4, bank count; power of two, ≥2
- NUM_RD, 3, operand-collector read channels
- NUM_WB, 2, writeback channels
- NUM_WARPS, 8, warps; power of two
- NUM_REGS, 32, architectural registers per warp; power of two, multiple of NUM_BANKS
- DATA_W, 32, register data width
- Derived: WARP_W=$clog2(NUM_WARPS), REG_W=$clog2(NUM_REGS), ROWS=NUM_WARPS*NUM_REGS/NUM_BANKS

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; 0 = freeze
- rd_req_valid  in  NUM_RD  read request valid per channel
- rd_req_ready  out  NUM_RD  read request granted this cycle (combinational)
- rd_req_warp  in  NUM_RD*WARP_W  warp id per channel
- rd_req_reg  in  NUM_RD*REG_W  register id per channel
- rd_resp_valid  out  NUM_RD  read data valid (registered)
- rd_resp_data  out  NUM_RD*DATA_W  read data
- wb_valid  in  NUM_WB  writeback valid
- wb_ready  out  NUM_WB  writeback accepted this cycle (combinational)
- wb_warp  in  NUM_WB*WARP_W  writeback warp id
- wb_reg  in  NUM_WB*REG_W  writeback register id
- wb_data  in  NUM_WB*DATA_W  writeback data

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Single clock domain (clk); rst sampled on the rising edge of clk.
- Bank mapping:
  - bank = (reg + warp) mod NUM_BANKS
  - row = warp*(NUM_REGS/NUM_BANKS) + reg/NUM_BANKS
- Each bank is 1R1W: one read and one write per cycle.
- Read arbitration, per bank:
  - Contenders are channels with rd_req_valid=1 mapping to that bank.
  - Round-robin pointer rr[b]. The winner is the first contender at index ≥ rr[b], wrapping to 0.
  - On grant, rr[b] ← winner+1 mod NUM_RD. With no grant, rr[b] is unchanged.
  - rd_req_ready[i]=1 iff channel i wins its bank and rdy=1.
  - Losers hold their request; there is no queuing inside the block.
  - Ready does not depend on downstream state.
- Read latency: a request accepted at cycle t gives rd_resp_valid[i]=1 and rd_resp_data[i] at t+1, for exactly one cycle.
  - Back-to-back accepts on one channel give back-to-back responses.
  - rd_resp_data is don't-care when valid=0.
- Write arbitration, per bank: among wb_valid channels mapping to the bank, the lowest index wins. wb_ready[j]=1 iff channel j wins and rdy=1. The write commits at the clock edge of acceptance.
- Simultaneous read and write of the same bank/row in one cycle: the read returns the OLD value (write-after-read), unless the bypass feature is enabled.
- Two write channels to the same register: the lower index commits; the higher index sees wb_ready=0 and retries.
- rdy=0:
  - All ready outputs are 0; no storage or rr update.
  - rd_resp_valid clears to 0 at the next edge.
  - Any in-flight response (accepted at t while rdy=1) still appears at t+1 regardless of rdy at t+1.
- Reset:
  - rd_resp_valid ← 0; rr[b] ← 0 for all banks.
  - Storage is not reset; a read before any write returns undefined data.
  - Reset asserted mid-operation drops the in-flight response: rd_resp_valid=0 the cycle after rst.
- Out-of-range ids cannot occur, because all widths are exact powers of two.

Optional Feature:
- GELATO_RF_WB_BYPASS_EN
- Defined:
  - A read accepted in the same cycle as a write to the same warp/reg returns the NEW (written) data at t+1.
  - Same-bank forwarding only; implemented as a registered compare plus mux on the bank output.
- Undefined:
  - The read returns the old value.
  - No compare logic is instantiated.

Test Plan (default parameters):
- Write w3/r5=0xDEAD_BEEF via wb0. Next cycle, ch0 reads w3/r5 → rd_req_ready[0]=1, rd_resp_valid[0]=1 one cycle later, data=0xDEAD_BEEF.
- Conflict round-robin:
  - Setup: ch0, ch1, ch2 all hold requests to bank 0 (w0/r0, w1/r3, w2/r2) continuously from reset.
  - Expected: grants are ch0, ch1, ch2, ch0 on consecutive cycles, one response per cycle.
- No conflict: ch0 w0/r0 (bank 0), ch1 w0/r1 (bank 1), ch2 w1/r1 (bank 2) in one cycle → all three ready=1 and all three responses valid at t+1.
- Write conflict: wb0 and wb1 both target w2/r2 in the same cycle, data 0x1 and 0x2 → wb_ready=2'b01. wb1 retries next cycle, then a read returns 0x2.
- Same-cycle read/write:
  - Setup: w4/r7 holds 0x11; in one cycle wb0 writes 0x22 to it while ch1 reads it.
  - Expected: ch1 response is 0x11 without GELATO_RF_WB_BYPASS_EN, 0x22 with it. A subsequent read returns 0x22.
- Freeze/reset:
  - rdy=0 for 3 cycles with requests pending → all ready=0 and rr unchanged; grant order resumes from the prior rr when rdy returns.
  - rst asserted the cycle after an accept → rd_resp_valid=0.
